// File: rtl/mem_map_pkg.sv
// mem_map_pkg: bus memory map shared by the responder and MemCtrl
package mem_map_pkg;
  localparam logic [31:0] IO_BASE = 32'h30000;
  localparam logic [31:0] IO_TX_ADDR = 32'h30000;
  localparam logic [31:0] IO_END_ADDR = 32'h30004;
  localparam int IO_SEL_HI = 17;
  localparam int IO_SEL_LO = 16;
  localparam logic [1:0] IO_SEL = IO_BASE[IO_SEL_HI:IO_SEL_LO];
  function automatic logic is_io(input logic [31:0] addr);
    return addr[IO_SEL_HI:IO_SEL_LO] == IO_SEL;
  endfunction
endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: circular byte FIFO; exposes both current and next-cycle fill level
module byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [7:0]    data_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o,
  output logic [CW-1:0] count_nxt_o
);
  logic [7:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  // A pop frees the head slot first, so a full FIFO may still take a push in the same cycle
  always_comb begin
    do_pop = en_i && pop_i && !empty_o;
    do_push = en_i && push_i && (!full_o || do_pop);
    wr_d = do_push ? wr_q + AW'(1) : wr_q;
    rd_d = do_pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
  end
  assign full_o = cnt_q == CW'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign data_o = mem_q[rd_q];
  assign count_o = cnt_q;
  assign count_nxt_o = cnt_d;
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end
endmodule

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: byte RAM plus TX/RX IO FIFOs behind MemCtrl's byte bus
module mem_bus_responder
  import mem_map_pkg::*;
#(
  parameter int RAM_AW = 17,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        w_r,
  input  logic [31:0] addr_input,
  input  logic [7:0]  data_input,
  output logic [7:0]  data_output,
  output logic        io_buffer_full,
  output logic        tx_valid,
  output logic [7:0]  tx_data,
  input  logic        tx_ready,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        sim_end,
  output logic        tx_overflow
);
  localparam int TX_CW = $clog2(TX_DEPTH) + 1;
  localparam int RX_CW = $clog2(RX_DEPTH) + 1;
  logic [7:0] ram_q [2**RAM_AW];
  logic [RAM_AW-1:0] idx;
  logic io, tx_sel, end_sel, ram_we;
  logic [7:0] data_q, data_d, rx_head;
  logic full_q, full_d, sim_end_q, sim_end_d, ovf_q, ovf_d;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic [TX_CW-1:0] tx_cnt, tx_cnt_nxt;
  logic [RX_CW-1:0] rx_cnt, rx_cnt_nxt;
  logic unused_cnt;
  assign idx = addr_input[RAM_AW-1:0];
  assign io = is_io(addr_input);
  assign tx_sel = addr_input == IO_TX_ADDR;
  assign end_sel = addr_input == IO_END_ADDR;
  assign ram_we = rdy && w_r && !io;
  assign unused_cnt = ^{tx_cnt, rx_cnt, rx_cnt_nxt};
  byte_fifo #(.DEPTH(TX_DEPTH)) u_tx (
    .clk(clk), .rst(rst), .en_i(rdy),
    .push_i(w_r && tx_sel), .pop_i(tx_ready), .data_i(data_input),
    .data_o(tx_data), .full_o(tx_full), .empty_o(tx_empty),
    .count_o(tx_cnt), .count_nxt_o(tx_cnt_nxt)
  );
  byte_fifo #(.DEPTH(RX_DEPTH)) u_rx (
    .clk(clk), .rst(rst), .en_i(rdy),
    .push_i(rx_valid && rx_ready), .pop_i(!w_r && tx_sel), .data_i(rx_data),
    .data_o(rx_head), .full_o(rx_full), .empty_o(rx_empty),
    .count_o(rx_cnt), .count_nxt_o(rx_cnt_nxt)
  );
  assign tx_valid = !tx_empty;
  assign rx_ready = !rx_full;
  // Full is flagged two slots early because MemCtrl only reacts a cycle after seeing it
  always_comb begin
    data_d = (rdy && !w_r) ? (io ? ((tx_sel && !rx_empty) ? rx_head : 8'h00) : ram_q[idx]) : data_q;
    full_d = rdy ? (tx_cnt_nxt >= TX_CW'(TX_DEPTH - 2)) : full_q;
    sim_end_d = rdy && w_r && end_sel;
    ovf_d = ovf_q || (rdy && w_r && tx_sel && tx_full && !tx_ready);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      data_q <= '0;
      full_q <= 1'b0;
      sim_end_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      data_q <= data_d;
      full_q <= full_d;
      sim_end_q <= sim_end_d;
      ovf_q <= ovf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (ram_we) ram_q[idx] <= data_input;
  end
  assign data_output = data_q;
  assign io_buffer_full = full_q;
  assign sim_end = sim_end_q;
  assign tx_overflow = ovf_q;
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: scoreboard bench; read and TX results are checked by a negedge monitor
module tb_mem_bus_responder;
  logic clk = 1'b0, rst = 1'b0, rdy = 1'b1, w_r = 1'b0, tx_ready = 1'b0, rx_valid = 1'b0;
  logic [31:0] addr_input = '0;
  logic [7:0] data_input = '0, rx_data = '0;
  logic [7:0] data_output, tx_data;
  logic io_buffer_full, tx_valid, rx_ready, sim_end, tx_overflow;
  int checks = 0, errors = 0;
  logic [7:0] rd_exp[$], tx_exp[$];
  logic [7:0] mon_e;
  logic chk = 1'b0, pend = 1'b0;

  mem_bus_responder dut (
    .clk(clk), .rst(rst), .rdy(rdy), .w_r(w_r), .addr_input(addr_input),
    .data_input(data_input), .data_output(data_output), .io_buffer_full(io_buffer_full),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready), .sim_end(sim_end), .tx_overflow(tx_overflow)
  );

  always #5 clk = ~clk;

  // Inputs seen at a negedge are what the next posedge samples; outputs reflect the previous posedge
  always @(negedge clk) begin
    if (pend) begin
      checks++;
      if (rd_exp.size() == 0) begin
        errors++;
        $display("FAIL rd_sb: data_output=0x%02h with no expected read queued", data_output);
      end else begin
        mon_e = rd_exp.pop_front();
        if (data_output !== mon_e) begin
          errors++;
          $display("FAIL rd_sb: data_output=0x%02h expected 0x%02h", data_output, mon_e);
        end
      end
    end
    pend = rst && rdy && !w_r && chk;
    if (rst && rdy && tx_valid && tx_ready) begin
      checks++;
      if (tx_exp.size() == 0) begin
        errors++;
        $display("FAIL tx_sb: unexpected tx byte 0x%02h", tx_data);
      end else begin
        mon_e = tx_exp.pop_front();
        if (tx_data !== mon_e) begin
          errors++;
          $display("FAIL tx_sb: tx_data=0x%02h expected 0x%02h", tx_data, mon_e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic w, input logic [31:0] a, input logic [7:0] d, input logic c);
    step();
    w_r = w;
    addr_input = a;
    data_input = d;
    chk = c;
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    drive(1'b1, a, d, 1'b0);
  endtask

  task automatic rd(input logic [31:0] a, input logic [7:0] e);
    rd_exp.push_back(e);
    drive(1'b0, a, 8'h00, 1'b1);
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 8'h00, 1'b0);
  endtask

  task automatic settle();
    idle();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) step();
    @(negedge clk);
    checks++;
    if ({data_output, io_buffer_full, sim_end, tx_overflow, tx_valid, rx_ready} !== {8'h00, 5'b00001}) begin
      errors++;
      $display("FAIL reset_state: {dout,full,end,ovf,txv,rxr}=%h expected %h",
               {data_output, io_buffer_full, sim_end, tx_overflow, tx_valid, rx_ready}, {8'h00, 5'b00001});
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_ram();
    wr(32'h00010, 8'hA5);
    wr(32'h00011, 8'h3C);
    rd(32'h00010, 8'hA5);
    rd(32'h00011, 8'h3C);
    rd(32'h40010, 8'hA5);
    settle();
  endtask

  task automatic test_tx();
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tx_exp.push_back(8'(8'h41 + i));
      wr(32'h30000, 8'(8'h41 + i));
    end
    settle();
    checks++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      errors++;
      $display("FAIL tx_head: valid=%b data=0x%02h expected 1 0x41", tx_valid, tx_data);
    end
    step();
    tx_ready = 1'b1;
    repeat (3) step();
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_exp.size() != 0) begin
      errors++;
      $display("FAIL tx_drain: valid=%b left=%0d expected 0 0", tx_valid, tx_exp.size());
    end
  endtask

  task automatic test_back_to_back();
    step();
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tx_exp.push_back(8'(i));
      wr(32'h30000, 8'(i));
      @(negedge clk);
      checks++;
      if (io_buffer_full !== 1'b0 || tx_overflow !== 1'b0) begin
        errors++;
        $display("FAIL b2b_flags: i=%0d full=%b ovf=%b expected 0 0", i, io_buffer_full, tx_overflow);
      end
    end
    settle();
    step();
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_exp.size() != 0 || tx_overflow !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end: valid=%b left=%0d ovf=%b expected 0 0 0", tx_valid, tx_exp.size(), tx_overflow);
    end
  endtask

  task automatic test_rx_end();
    rd(32'h30000, 8'h00);
    idle();
    rx_valid = 1'b1;
    rx_data = 8'h7F;
    rd(32'h30000, 8'h7F);
    rx_valid = 1'b0;
    rd(32'h30000, 8'h00);
    idle();
    rx_valid = 1'b1;
    rx_data = 8'h22;
    rd(32'h30008, 8'h00);
    rx_valid = 1'b0;
    rd(32'h30000, 8'h22);
    idle();
    rx_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rx_data = 8'(8'h10 + k);
      step();
    end
    rx_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL rx_full: rx_ready=%b expected 0", rx_ready);
    end
    for (int k = 0; k < 4; k++) rd(32'h30000, 8'(8'h10 + k));
    settle();
    checks++;
    if (sim_end !== 1'b0 || rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL pre_end: sim_end=%b rx_ready=%b expected 0 1", sim_end, rx_ready);
    end
    wr(32'h30004, 8'h00);
    settle();
    checks++;
    if (sim_end !== 1'b1) begin
      errors++;
      $display("FAIL sim_end_on: sim_end=%b expected 1", sim_end);
    end
    idle();
    @(negedge clk);
    checks++;
    if (sim_end !== 1'b0) begin
      errors++;
      $display("FAIL sim_end_off: sim_end=%b expected 0", sim_end);
    end
  endtask

  task automatic test_backpressure();
    tx_ready = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      if (i <= 8) tx_exp.push_back(8'(8'h50 + i));
      wr(32'h30000, 8'(8'h50 + i));
      settle();
      checks++;
      if (io_buffer_full !== (i >= 6) || tx_overflow !== (i >= 9)) begin
        errors++;
        $display("FAIL bp_flags: write %0d full=%b ovf=%b expected %b %b",
                 i, io_buffer_full, tx_overflow, i >= 6, i >= 9);
      end
    end
    checks++;
    if (tx_data !== 8'h51) begin
      errors++;
      $display("FAIL bp_head: tx_data=0x%02h expected 0x51", tx_data);
    end
    step();
    tx_ready = 1'b1;
    repeat (8) step();
    tx_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_valid !== 1'b0 || tx_exp.size() != 0 || io_buffer_full !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: valid=%b left=%0d full=%b expected 0 0 0", tx_valid, tx_exp.size(), io_buffer_full);
    end
  endtask

  task automatic test_rdy_reset();
    rd(32'h00010, 8'hA5);
    step();
    rdy = 1'b0;
    w_r = 1'b1;
    addr_input = 32'h30000;
    data_input = 8'h99;
    chk = 1'b0;
    step();
    w_r = 1'b0;
    addr_input = 32'h00011;
    step();
    rdy = 1'b1;
    addr_input = 32'h0;
    @(negedge clk);
    checks++;
    if (data_output !== 8'hA5 || tx_valid !== 1'b0) begin
      errors++;
      $display("FAIL rdy_hold: dout=0x%02h txv=%b expected 0xa5 0", data_output, tx_valid);
    end
    wr(32'h01234, 8'h5A);
    for (int i = 0; i < 6; i++) wr(32'h30000, 8'(8'hC0 + i));
    settle();
    checks++;
    if (io_buffer_full !== 1'b1 || tx_valid !== 1'b1 || tx_overflow !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst: full=%b txv=%b ovf=%b expected 1 1 1", io_buffer_full, tx_valid, tx_overflow);
    end
    step();
    rst = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({data_output, io_buffer_full, sim_end, tx_overflow, tx_valid, rx_ready} !== {8'h00, 5'b00001}) begin
      errors++;
      $display("FAIL mid_rst: {dout,full,end,ovf,txv,rxr}=%h expected %h",
               {data_output, io_buffer_full, sim_end, tx_overflow, tx_valid, rx_ready}, {8'h00, 5'b00001});
    end
    rd(32'h01234, 8'h5A);
    tx_ready = 1'b1;
    repeat (3) settle();
    tx_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_ram();
    test_tx();
    test_back_to_back();
    test_rx_end();
    test_backpressure();
    test_rdy_reset();
    @(negedge clk);
    checks++;
    if (rd_exp.size() != 0 || tx_exp.size() != 0) begin
      errors++;
      $display("FAIL sb_empty: reads left=%0d tx left=%0d expected 0 0", rd_exp.size(), tx_exp.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
